// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Brief    : Shared types for the unified-memory port arbiter.
// Revision : 1.0
// ============================================================================
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IFETCH = 1'b0,
        OWN_DATA   = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick2
// Brief    : Two-way round-robin picker; bit 0 = ifetch, bit 1 = data.
// Revision : 1.0
// ============================================================================
module rr_pick2
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_FIRST = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    owner_t     r_lastOwner;
    logic [1:0] w_pick;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        w_pick = req;
        if (req == 2'b11) begin
            w_pick = (r_lastOwner == OWN_DATA) ? 2'b01 : 2'b10;
        end
    end

    assign gnt = en ? w_pick : 2'b00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lastOwner <= (DATA_FIRST != 0) ? OWN_IFETCH : OWN_DATA;
        end else if (gnt != 2'b00) begin
            r_lastOwner <= gnt[1] ? OWN_DATA : OWN_IFETCH;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one single-port memory between ifetch and data requesters.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int TIMEOUT    = 255,
    parameter int DATA_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err
);

    localparam logic [31:0] c_TIMEOUT_LAST = 32'(TIMEOUT - 1);

    arb_state_t        r_state;
    owner_t            r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [31:0]       r_cnt;
    logic              r_iRvalid;
    logic              r_dRvalid;
    logic              r_err;
    logic [DATA_W-1:0] r_iRdata;
    logic [DATA_W-1:0] r_dRdata;

    logic [1:0]        w_gnt;
    logic              w_grantEn;
    logic              w_timeout;

    // Gating with reset keeps the grant low while reset is held.
    assign w_grantEn = (r_state == IDLE) && reset;
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == c_TIMEOUT_LAST);

    rr_pick2 #(
        .DATA_FIRST (DATA_FIRST)
    ) u_pick (
        .clk   (clk),
        .reset (reset),
        .req   ({d_req, i_req}),
        .en    (w_grantEn),
        .gnt   (w_gnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_owner   <= OWN_IFETCH;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_iRvalid <= 1'b0;
            r_dRvalid <= 1'b0;
            r_err     <= 1'b0;
            r_iRdata  <= '0;
            r_dRdata  <= '0;
        end else begin
            r_iRvalid <= 1'b0;
            r_dRvalid <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt != 2'b00) begin
                        r_state <= BUSY;
                        r_cnt   <= '0;
                        if (w_gnt[1]) begin
                            r_owner <= OWN_DATA;
                            r_we    <= d_we;
                            r_addr  <= d_addr;
                            r_wdata <= d_wdata;
                        end else begin
                            r_owner <= OWN_IFETCH;
                            r_we    <= 1'b0;
                            r_addr  <= i_addr;
                            r_wdata <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        r_state <= RESP;
                        if (r_owner == OWN_DATA) begin
                            r_dRvalid <= 1'b1;
                            if (!r_we) begin
                                r_dRdata <= mem_rdata;
                            end
                        end else begin
                            r_iRvalid <= 1'b1;
                            r_iRdata  <= mem_rdata;
                        end
                    end else if (w_timeout) begin
                        r_state <= RESP;
                        r_err   <= 1'b1;
                        if (r_owner == OWN_DATA) begin
                            r_dRvalid <= 1'b1;
                            r_dRdata  <= '0;
                        end else begin
                            r_iRvalid <= 1'b1;
                            r_iRdata  <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign i_gnt     = w_gnt[0];
    assign d_gnt     = w_gnt[1];
    assign i_rvalid  = r_iRvalid;
    assign d_rvalid  = r_dRvalid;
    assign i_rdata   = r_iRdata;
    assign d_rdata   = r_dRdata;
    assign err       = r_err;
    assign busy      = (r_state != IDLE);
    assign mem_req   = (r_state == BUSY);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed table, corner sequences and random run against a model.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt, i_rvalid;
    logic [63:0] i_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_gnt, d_rvalid;
    logic [63:0] d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        busy, err;

    mem_port_arbiter #(
        .ADDR_W (32), .DATA_W (64), .TIMEOUT (TO), .DATA_FIRST (1)
    ) dut (
        .clk (clk), .reset (reset),
        .i_req (i_req), .i_addr (i_addr), .i_gnt (i_gnt),
        .i_rvalid (i_rvalid), .i_rdata (i_rdata),
        .d_req (d_req), .d_we (d_we), .d_addr (d_addr), .d_wdata (d_wdata),
        .d_gnt (d_gnt), .d_rvalid (d_rvalid), .d_rdata (d_rdata),
        .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr),
        .mem_wdata (mem_wdata), .mem_ack (mem_ack), .mem_rdata (mem_rdata),
        .busy (busy), .err (err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          isD;
        bit          we;
        logic [31:0] addr;
        logic [63:0] wdata;
        int          k;
        logic [63:0] memData;
        int          rv;
        bit          expErr;
        logic [63:0] expRdata;
    } row_t;

    row_t rows[8];

    task automatic idleInputs();
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        mem_ack = 0; mem_rdata = 0;
    endtask

    task automatic resetPulse();
        @(negedge clk);
        idleInputs();
        reset = 0;
        @(negedge clk);
        reset = 1;
    endtask

    // One isolated transaction; rv is the rvalid cycle relative to the grant.
    task automatic runRow(input row_t r);
        @(negedge clk);
        i_req = !r.isD; i_addr = r.addr;
        d_req = r.isD;  d_we = r.we; d_addr = r.addr; d_wdata = r.wdata;
        mem_ack = 0;
        #1;
        chk("row gnt", r.isD ? d_gnt : i_gnt, 1);
        chk("row other gnt", r.isD ? i_gnt : d_gnt, 0);
        for (int c = 1; c <= r.rv + 1; c++) begin
            @(negedge clk);
            i_req = 0; d_req = 0;
            i_addr = $urandom; d_addr = $urandom; d_wdata = {$urandom, $urandom};
            mem_ack   = (c == 1 + r.k);
            mem_rdata = (c == 1 + r.k) ? r.memData : {$urandom, $urandom};
            #1;
            chk("row mem_req", mem_req, c < r.rv);
            if (c < r.rv) begin
                chk("row mem_we", mem_we, r.isD ? r.we : 1'b0);
                chk("row mem_addr", mem_addr, r.addr);
                chk("row mem_wdata", mem_wdata, r.isD ? r.wdata : 64'd0);
            end
            chk("row rvalid", r.isD ? d_rvalid : i_rvalid, c == r.rv);
            chk("row other rvalid", r.isD ? i_rvalid : d_rvalid, 0);
            chk("row err", err, (c == r.rv) && r.expErr);
            chk("row busy", busy, c <= r.rv);
            if (c >= r.rv) chk("row rdata", r.isD ? d_rdata : i_rdata, r.expRdata);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rows[0] = '{1, 0, 32'h40,  64'h0,    2,  64'hDEADBEEF_00000001, 4, 0, 64'hDEADBEEF_00000001};
        rows[1] = '{1, 1, 32'h80,  64'h1234, 0,  64'hAAAA,              2, 0, 64'hDEADBEEF_00000001};
        rows[2] = '{0, 0, 32'h100, 64'h0,    1,  64'h01234567_89ABCDEF, 3, 0, 64'h01234567_89ABCDEF};
        rows[3] = '{1, 0, 32'hC0,  64'h9,    3,  64'hCAFE,              5, 0, 64'hCAFE};
        rows[4] = '{1, 0, 32'hC8,  64'h0,    10, 64'h1111,              5, 1, 64'h0};
        rows[5] = '{0, 0, 32'h104, 64'h0,    10, 64'h2222,              5, 1, 64'h0};
        rows[6] = '{1, 0, 32'hD0,  64'h0,    0,  64'h77,                2, 0, 64'h77};
        rows[7] = '{1, 1, 32'hD8,  64'h55,   10, 64'h3333,              5, 1, 64'h0};

        // Reset state
        idleInputs();
        reset = 0;
        #3;
        chk("rst busy", busy, 0);
        chk("rst mem_req", mem_req, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst rvalids", {i_rvalid, d_rvalid, err}, 0);
        chk("rst rdata", i_rdata | d_rdata, 0);
        @(negedge clk);
        reset = 1;

        for (int n = 0; n < 8; n++) runRow(rows[n]);

        // Contention from reset, immediate acks: data wins first, then alternate.
        resetPulse();
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            i_req = 1; d_req = 1; d_we = 0; mem_ack = 1; mem_rdata = 64'(c);
            #1;
            chk("cont d_gnt",    d_gnt,    (c % 3 == 0) && ((c / 3) % 2 == 0));
            chk("cont i_gnt",    i_gnt,    (c % 3 == 0) && ((c / 3) % 2 == 1));
            chk("cont d_rvalid", d_rvalid, (c % 3 == 2) && ((c / 3) % 2 == 0));
            chk("cont i_rvalid", i_rvalid, (c % 3 == 2) && ((c / 3) % 2 == 1));
            if ((c % 3 == 2) && ((c / 3) % 2 == 1)) chk("cont i_rdata", i_rdata, 64'(c - 1));
        end
        repeat (3) begin
            @(negedge clk);
            i_req = 0; d_req = 0; mem_ack = 1;
        end

        // Reset while BUSY drops the transaction.
        @(negedge clk);
        mem_ack = 0; d_req = 1; d_we = 0; d_addr = 32'h200;
        #1 chk("rb d_gnt", d_gnt, 1);
        @(negedge clk);
        d_req = 0; i_req = 1; i_addr = 32'h204;
        #1;
        chk("rb mem_req", mem_req, 1);
        chk("rb i_gnt pending", i_gnt, 0);
        #2 reset = 0;
        #1;
        chk("rb async mem_req", mem_req, 0);
        chk("rb async busy", busy, 0);
        chk("rb async gnt", {i_gnt, d_gnt}, 0);
        chk("rb async rdata", d_rdata | i_rdata, 0);
        @(negedge clk);
        reset = 1;
        #1 chk("rb fresh i_gnt", i_gnt, 1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            i_req = 0; mem_ack = (c == 1); mem_rdata = 64'hF00D;
            #1;
            chk("rb d_rvalid", d_rvalid, 0);
            chk("rb err", err, 0);
            chk("rb i_rvalid", i_rvalid, c == 2);
        end

        // Withdrawn ifetch request and stray ack in IDLE.
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            d_req = (c == 0); d_we = 0; d_addr = 32'h300;
            i_req = (c == 1) || (c == 2);
            mem_ack = (c == 3) || (c == 7); mem_rdata = 64'h5A5A;
            #1;
            chk("wd d_gnt", d_gnt, c == 0);
            chk("wd i_gnt", i_gnt, 0);
            chk("wd d_rvalid", d_rvalid, c == 4);
            chk("wd i_rvalid", i_rvalid, 0);
            chk("wd busy", busy, (c >= 1) && (c <= 4));
            if (c >= 4) chk("wd d_rdata", d_rdata, 64'h5A5A);
        end

        // Randomized run against a transaction-timeline model.
        resetPulse();
        begin
            int          freeAt = 0, txT = -100, txK = 0, txKeff = 0;
            bit          txIsD = 0, txWe = 0, txTo = 0, lastData = 0;
            bit          iPend = 0, dPend = 0, dWe = 0, inBusy, idle, pickD;
            bit          eIg, eDg;
            logic [31:0] iA = 0, dA = 0, txAddr = 0;
            logic [63:0] dW = 0, txWdata = 0, ackData = 0, expI = 0, expD = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                @(negedge clk);
                if (!iPend && $urandom_range(0, 2) == 0) begin
                    iPend = 1; iA = $urandom;
                end else if (iPend && $urandom_range(0, 15) == 0) iPend = 0;
                if (!dPend && $urandom_range(0, 2) == 0) begin
                    dPend = 1; dA = $urandom; dWe = $urandom_range(0, 1) == 1; dW = {$urandom, $urandom};
                end else if (dPend && $urandom_range(0, 15) == 0) dPend = 0;
                i_req = iPend; i_addr = iA;
                d_req = dPend; d_addr = dA; d_we = dWe; d_wdata = dW;
                inBusy = (cyc >= txT + 1) && (cyc <= txT + 1 + txKeff);
                mem_ack = inBusy ? (cyc == txT + 1 + txK) : ($urandom_range(0, 3) == 0);
                mem_rdata = {$urandom, $urandom};
                if (inBusy && cyc == txT + 1 + txK) ackData = mem_rdata;
                if (cyc == txT + 2 + txKeff) begin
                    if (txTo) begin
                        if (txIsD) expD = 0; else expI = 0;
                    end else if (txIsD) begin
                        if (!txWe) expD = ackData;
                    end else expI = ackData;
                end
                #1;
                idle = cyc >= freeAt;
                chk("rnd busy", busy, !idle);
                chk("rnd mem_req", mem_req, inBusy);
                if (inBusy) begin
                    chk("rnd mem_we", mem_we, txWe);
                    chk("rnd mem_addr", mem_addr, txAddr);
                    chk("rnd mem_wdata", mem_wdata, txWdata);
                end
                chk("rnd i_rvalid", i_rvalid, (cyc == txT + 2 + txKeff) && !txIsD);
                chk("rnd d_rvalid", d_rvalid, (cyc == txT + 2 + txKeff) && txIsD);
                chk("rnd err", err, (cyc == txT + 2 + txKeff) && txTo);
                chk("rnd i_rdata", i_rdata, expI);
                chk("rnd d_rdata", d_rdata, expD);
                eIg = 0; eDg = 0;
                if (idle && (iPend || dPend)) begin
                    pickD = dPend && (!iPend || !lastData);
                    eDg = pickD; eIg = !pickD;
                    lastData = pickD;
                    txT = cyc; txIsD = pickD;
                    txK = $urandom_range(0, 6);
                    txTo = txK >= TO;
                    txKeff = txTo ? TO - 1 : txK;
                    freeAt = cyc + 3 + txKeff;
                    txWe = pickD ? dWe : 1'b0;
                    txAddr = pickD ? dA : iA;
                    txWdata = pickD ? dW : 64'd0;
                    if (pickD) dPend = 0; else iPend = 0;
                end
                chk("rnd i_gnt", i_gnt, eIg);
                chk("rnd d_gnt", d_gnt, eDg);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
